// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state and word types for the FIFO read-side stream adapter
package fifo_rd_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} rd_state_t;
    typedef struct packed {
        logic                      last;
        logic [DEF_DATA_WIDTH-1:0] data;
    } stream_word_t;
endpackage

// File: rtl/frame_counter.sv
// frame_counter: modulo-FRAME_LEN word counter flagging the last word of each frame
module frame_counter #(
    parameter int FRAME_LEN = 8,
    parameter int FL_W      = 16
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic inc,
    output logic is_last
);
    logic [FL_W-1:0] cnt;
    assign is_last = cnt == FL_W'(FRAME_LEN - 1);
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) cnt <= '0;
        else if (inc) cnt <= is_last ? '0 : cnt + FL_W'(1);
endmodule

// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: drains an FWFT FIFO read port into a registered valid/ready stream via a 2-entry skid buffer
// Optional word/stall statistics ports are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 8,
    parameter int FL_W       = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rpull,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [31:0]           stall_cnt
`endif
);
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } word_t;
    rd_state_t state, state_n;
    word_t     head, skid, in_word;
    logic      push, pop, is_last, head_en, skid_en;
    // Gated by reset so no FIFO word is popped while the buffer cannot capture it
    assign rpull   = rrst_n & !rempty & (state != ST_TWO);
    assign push    = rpull;
    assign m_valid = state != ST_EMPTY;
    assign pop     = m_valid & m_ready;
    assign m_data  = head.data;
    assign m_last  = head.last;
    assign in_word = {is_last, rdata};
    frame_counter #(.FRAME_LEN(FRAME_LEN), .FL_W(FL_W)) u_frame (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .inc     (push),
        .is_last (is_last)
    );
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) state <= ST_EMPTY;
        else state <= state_n;
    always_comb begin
        state_n = state;
        head_en = 1'b0;
        skid_en = 1'b0;
        case (state)
            ST_EMPTY: begin
                head_en = push;
                state_n = push ? ST_ONE : ST_EMPTY;
            end
            ST_ONE: begin
                head_en = push & pop;
                skid_en = push & !pop;
                state_n = (push & !pop) ? ST_TWO : (pop & !push) ? ST_EMPTY : ST_ONE;
            end
            ST_TWO: begin
                head_en = pop;
                state_n = pop ? ST_ONE : ST_TWO;
            end
            default: state_n = ST_EMPTY;
        endcase
    end
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (head_en) head <= (state == ST_TWO) ? skid : in_word;
            if (skid_en) skid <= in_word;
        end
`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) word_cnt <= word_cnt + 32'd1;
            if (m_valid & !m_ready) stall_cnt <= stall_cnt + 32'd1;
        end
`endif
endmodule

// File: tb/tb_fifo_rd_adapter.sv
// tb_fifo_rd_adapter: directed self-checking bench with a behavioural FWFT FIFO feeding the adapter
module tb_fifo_rd_adapter;
    logic        rclk = 1'b0;
    logic        rrst_n, rempty, rpull, m_valid, m_ready, m_last;
    logic [31:0] rdata, m_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_cnt, stall_cnt;
    int          stall_exp = 0;
`endif
    logic [31:0] mem [64];
    int          wr_ptr = 0, rd_ptr = 0;
    logic [31:0] rx_data [128];
    logic        rx_last [128];
    int          rx_n = 0, viol = 0;
    logic [31:0] exp_data [128];
    logic        exp_last [128];
    int          n_exp = 0, ord = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        rdy;
        logic        rpull;
        logic        valid;
        logic [31:0] data;
        logic        last;
    } vec_t;
    vec_t tab [15];

    always #5 rclk = ~rclk;

    fifo_rd_adapter #(.DATA_WIDTH(32), .FRAME_LEN(8), .FL_W(16)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rpull   (rpull),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    assign rempty = rd_ptr == wr_ptr;
    assign rdata  = mem[rd_ptr % 64];

    always @(posedge rclk) begin
        if (rpull) rd_ptr <= rd_ptr + 1;
        if (rpull && rempty) viol <= viol + 1;
        if (rrst_n && m_valid && m_ready) begin
            rx_data[rx_n] <= m_data;
            rx_last[rx_n] <= m_last;
            rx_n <= rx_n + 1;
        end
    end
`ifdef FIFO_RD_STATS_EN
    always @(posedge rclk or negedge rrst_n)
        if (!rrst_n) stall_exp <= 0;
        else if (m_valid && !m_ready) stall_exp <= stall_exp + 1;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic push_exp(input logic [31:0] d);
        exp_data[n_exp] = d;
        exp_last[n_exp] = (ord % 8) == 7;
        n_exp++;
        ord++;
    endtask

    task automatic wait_rx(input string nm);
        for (int i = 0; i < 200 && rx_n < n_exp; i++) @(negedge rclk);
        chk(nm, rx_n, n_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tab[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        tab[1]  = '{1'b0, 1'b1, 1'b1, 32'h50, 1'b0};
        for (int i = 2; i < 10; i++) tab[i] = '{1'b0, 1'b0, 1'b1, 32'h50, 1'b0};
        tab[10] = '{1'b1, 1'b0, 1'b1, 32'h50, 1'b0};
        tab[11] = '{1'b1, 1'b1, 1'b1, 32'h51, 1'b0};
        tab[12] = '{1'b1, 1'b1, 1'b1, 32'h52, 1'b0};
        tab[13] = '{1'b1, 1'b0, 1'b1, 32'h53, 1'b0};
        tab[14] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0};

        rrst_n  = 1'b1;
        m_ready = 1'b0;
        #1 rrst_n = 1'b0;
        for (int v = 2; v <= 11; v++) put(v);
        repeat (2) @(negedge rclk);
        #1;
        chk("reset rpull", rpull, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset m_last", m_last, 0);

        @(negedge rclk);
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        ord = 0;
        for (int v = 2; v <= 11; v++) push_exp(v);
        #1 chk("first rpull after release", rpull, 1);
        wait_rx("stream count");

        @(negedge rclk);
        m_ready = tab[0].rdy;
        for (int v = 'h50; v <= 'h53; v++) begin
            put(v);
            push_exp(v);
        end
        for (int i = 0; i < 15; i++) begin
            if (i > 0) begin
                @(negedge rclk);
                m_ready = tab[i].rdy;
            end
            #1;
            chk($sformatf("bp[%0d] rpull", i), rpull, tab[i].rpull);
            chk($sformatf("bp[%0d] m_valid", i), m_valid, tab[i].valid);
            if (tab[i].valid) begin
                chk($sformatf("bp[%0d] m_data", i), m_data, tab[i].data);
                chk($sformatf("bp[%0d] m_last", i), m_last, tab[i].last);
            end
        end
        chk("bp count", rx_n, n_exp);

        @(negedge rclk);
        for (int v = 'h100; v <= 'h113; v++) begin
            put(v);
            push_exp(v);
        end
        for (int i = 0; i < 200 && rx_n < n_exp; i++) begin
            m_ready = ~m_ready;
            @(negedge rclk);
        end
        chk("alt count", rx_n, n_exp);
`ifdef FIFO_RD_STATS_EN
        chk("word_cnt", word_cnt, 34);
        chk("stall_cnt", stall_cnt, stall_exp);
`endif

        @(negedge rclk);
        m_ready = 1'b1;
        put(32'hA5);
        push_exp(32'hA5);
        #1;
        chk("edge rpull", rpull, 1);
        chk("edge m_valid pre", m_valid, 0);
        @(negedge rclk);
        #1;
        chk("edge m_valid", m_valid, 1);
        chk("edge m_data", m_data, 32'hA5);
        chk("edge rpull empty", rpull, 0);
        @(negedge rclk);
        #1 chk("edge m_valid post", m_valid, 0);

        @(negedge rclk);
        m_ready = 1'b0;
        for (int v = 'h200; v <= 'h209; v++) put(v);
        repeat (2) @(negedge rclk);
        #1;
        chk("two rpull", rpull, 0);
        chk("two m_valid", m_valid, 1);
        chk("two m_data", m_data, 32'h200);
        #2 rrst_n = 1'b0;
        #1;
        chk("async m_valid", m_valid, 0);
        chk("async m_data", m_data, 0);
        @(negedge rclk);
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        ord = 0;
        for (int v = 'h202; v <= 'h209; v++) push_exp(v);
        wait_rx("post-reset count");
`ifdef FIFO_RD_STATS_EN
        chk("word_cnt post-reset", word_cnt, 8);
`endif

        for (int i = 0; i < n_exp && i < rx_n; i++) begin
            chk($sformatf("rx[%0d] data", i), rx_data[i], exp_data[i]);
            chk($sformatf("rx[%0d] last", i), rx_last[i], exp_last[i]);
        end
        chk("rpull while empty", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
